// File: rtl/idma_xif_issuer.sv
// Initiator-side Xif issuer: buffers DMA commands, issues them to the iDMA
// controller and throttles each direction by its count of in-flight transfers.
module idma_xif_issuer #(
  parameter int unsigned INSTR_W         = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned ID_W            = 4,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned DIRECTION_OFF   = 25,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [INSTR_W-1:0] cmd_instr_i,
  input  logic [DATA_W-1:0]  cmd_rs0_i,
  input  logic [DATA_W-1:0]  cmd_rs1_i,
  output logic               issue_valid_o,
  input  logic               issue_ready_i,
  output logic [INSTR_W-1:0] issue_instr_o,
  output logic [DATA_W-1:0]  issue_rs0_o,
  output logic [DATA_W-1:0]  issue_rs1_o,
  output logic [ID_W-1:0]    issue_id_o,
  input  logic               issue_accept_i,
  input  logic               axi2obi_done_i,
  input  logic               obi2axi_done_i,
  output logic [CNT_W-1:0]   a2o_pending_o,
  output logic [CNT_W-1:0]   o2a_pending_o,
  output logic               reject_err_o,
  output logic               count_err_o,
  output logic               idle_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  rs0;
    logic [DATA_W-1:0]  rs1;
  } cmd_t;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  cmd_t                  mem_q [FIFO_DEPTH];
  cmd_t                  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  state_e                state_q, state_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                  rej_q, rej_d, cerr_q, cerr_d;

  cmd_t       head;
  logic       head_dir, empty, push, hs;
  logic [1:0] inc, dec;

  assign head     = mem_q[rd_ptr_q];
  assign head_dir = head.instr[DIRECTION_OFF];
  assign empty    = (count_q == '0);
  assign cmd_ready_o = (count_q != DEPTH_CNT);
  assign push     = cmd_valid_i && cmd_ready_o;
  assign hs       = (state_q == ISSUE) && issue_ready_i;
  // index 0 = AXI2OBI, 1 = OBI2AXI, matching the instruction direction bit
  assign inc      = {2{hs && issue_accept_i}} & {head_dir, !head_dir};
  assign dec      = {obi2axi_done_i, axi2obi_done_i};

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    rej_d    = rej_q;
    cerr_d   = cerr_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{instr: cmd_instr_i, rs0: cmd_rs0_i, rs1: cmd_rs1_i};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (hs) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !hs)      count_d = count_q + 1'b1;
    else if (!push && hs) count_d = count_q - 1'b1;

    case (state_q)
      IDLE:  if (!empty && (cnt_q[head_dir] < MAX_CNT)) state_d = ISSUE;
      ISSUE: if (hs) begin
        state_d = IDLE;
        if (issue_accept_i) id_d  = id_q + 1'b1;
        else                rej_d = 1'b1;
      end
    endcase

    // simultaneous issue and done of one direction cancel out
    for (int d = 0; d < 2; d++) begin
      if (inc[d] && !dec[d]) begin
        cnt_d[d] = cnt_q[d] + 1'b1;
      end else if (dec[d] && !inc[d]) begin
        if (cnt_q[d] == '0) cerr_d   = 1'b1;
        else                cnt_d[d] = cnt_q[d] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      id_q     <= '0;
      cnt_q    <= '0;
      rej_q    <= 1'b0;
      cerr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      rej_q    <= rej_d;
      cerr_q   <= cerr_d;
    end
  end

  // Storage needs no reset: contents are only visible while an entry is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign issue_valid_o = (state_q == ISSUE);
  assign issue_instr_o = issue_valid_o ? head.instr : '0;
  assign issue_rs0_o   = issue_valid_o ? head.rs0   : '0;
  assign issue_rs1_o   = issue_valid_o ? head.rs1   : '0;
  assign issue_id_o    = id_q;
  assign a2o_pending_o = cnt_q[0];
  assign o2a_pending_o = cnt_q[1];
  assign reject_err_o  = rej_q;
  assign count_err_o   = cerr_q;
  assign idle_o        = empty && (state_q == IDLE) && (cnt_q == '0);

endmodule

// File: tb/tb_idma_xif_issuer.sv
// Directed bench for idma_xif_issuer with hand-computed expectations.
module tb_idma_xif_issuer;

  logic        clk = 1'b0;
  logic        rst_i, clear_i;
  logic        cmd_valid_i, cmd_ready_o;
  logic [31:0] cmd_instr_i, cmd_rs0_i, cmd_rs1_i;
  logic        issue_valid_o, issue_ready_i, issue_accept_i;
  logic [31:0] issue_instr_o, issue_rs0_o, issue_rs1_o;
  logic [3:0]  issue_id_o;
  logic        axi2obi_done_i, obi2axi_done_i;
  logic [2:0]  a2o_pending_o, o2a_pending_o;
  logic        reject_err_o, count_err_o, idle_o;

  int n_cmp = 0;
  int n_err = 0;

  idma_xif_issuer dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_instr_i(cmd_instr_i), .cmd_rs0_i(cmd_rs0_i), .cmd_rs1_i(cmd_rs1_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_instr_o(issue_instr_o), .issue_rs0_o(issue_rs0_o),
    .issue_rs1_o(issue_rs1_o), .issue_id_o(issue_id_o),
    .issue_accept_i(issue_accept_i),
    .axi2obi_done_i(axi2obi_done_i), .obi2axi_done_i(obi2axi_done_i),
    .a2o_pending_o(a2o_pending_o), .o2a_pending_o(o2a_pending_o),
    .reject_err_o(reject_err_o), .count_err_o(count_err_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // single-cycle push; caller guarantees cmd_ready_o
  task automatic push(input logic [31:0] instr, input logic [31:0] rs0, input logic [31:0] rs1);
    cmd_valid_i = 1'b1;
    cmd_instr_i = instr;
    cmd_rs0_i   = rs0;
    cmd_rs1_i   = rs1;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic pulse_a2o_done();
    axi2obi_done_i = 1'b1;
    tick();
    axi2obi_done_i = 1'b0;
  endtask

  localparam logic [31:0] O2A = 32'h0200_0000;

  initial begin
    int k, cyc;
    logic pushed;
    rst_i = 1'b1; clear_i = 1'b0; cmd_valid_i = 1'b0;
    cmd_instr_i = '0; cmd_rs0_i = '0; cmd_rs1_i = '0;
    issue_ready_i = 1'b1; issue_accept_i = 1'b1;
    axi2obi_done_i = 1'b0; obi2axi_done_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;

    // reset state
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_valid", issue_valid_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_data", {issue_instr_o, issue_rs0_o}, 0);
    chk("rst_cnt", {a2o_pending_o, o2a_pending_o, issue_id_o}, 0);

    // single accepted AXI2OBI command
    push(32'h0000_0001, 32'h1000, 32'h2000);
    chk("s1_valid_push", issue_valid_o, 0);
    chk("s1_idle_push", idle_o, 0);
    tick();
    chk("s1_valid", issue_valid_o, 1);
    chk("s1_req", {issue_id_o, issue_rs0_o, issue_rs1_o}, {4'd0, 32'h1000, 32'h2000});
    chk("s1_a2o0", a2o_pending_o, 0);
    tick();
    chk("s1_valid_after", issue_valid_o, 0);
    chk("s1_a2o1", a2o_pending_o, 1);
    chk("s1_idle_busy", idle_o, 0);
    pulse_a2o_done();
    chk("s1_a2o_done", a2o_pending_o, 0);
    chk("s1_idle_done", idle_o, 1);

    // back-pressure: request held stable for 5 cycles
    issue_ready_i = 1'b0;
    push(32'h0000_00AB, 32'h11, 32'h22);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("s2_hold_req", {issue_valid_o, issue_id_o, issue_instr_o}, {1'b1, 4'd1, 32'h0000_00AB});
      chk("s2_hold_rs", {issue_rs0_o, issue_rs1_o}, {32'h11, 32'h22});
      tick();
    end
    issue_ready_i = 1'b1;
    tick();
    chk("s2_issued", {issue_valid_o, a2o_pending_o, issue_id_o}, {1'b0, 3'd1, 4'd2});
    pulse_a2o_done();

    // FIFO full, throttle at MAX_OUTSTANDING for OBI2AXI
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    issue_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(O2A | 32'(i), 32'(i), 32'(i + 16));
    chk("s3_full", cmd_ready_o, 0);
    chk("s3_head", {issue_valid_o, issue_instr_o}, {1'b1, O2A});
    cmd_valid_i = 1'b1; cmd_instr_i = O2A | 32'd4;
    cmd_rs0_i = 32'd4; cmd_rs1_i = 32'd20;
    issue_ready_i = 1'b1;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 40) begin
      if (issue_valid_o) begin
        chk("s3_instr", issue_instr_o, O2A | 32'(k));
        chk("s3_id", issue_id_o, 64'(k));
        k++;
      end
      pushed = cmd_valid_i && cmd_ready_o;
      tick();
      if (pushed) cmd_valid_i = 1'b0;
      cyc++;
    end
    chk("s3_issued4", k, 4);
    chk("s3_push5", cmd_valid_i, 0);
    tick(); tick(); tick();
    chk("s3_throttled", {issue_valid_o, o2a_pending_o, idle_o}, {1'b0, 3'd4, 1'b0});
    obi2axi_done_i = 1'b1; tick(); obi2axi_done_i = 1'b0;
    chk("s3_o2a3", {issue_valid_o, o2a_pending_o}, {1'b0, 3'd3});
    tick();
    chk("s3_fifth", {issue_valid_o, issue_id_o, issue_instr_o}, {1'b1, 4'd4, O2A | 32'd4});
    tick();
    chk("s3_o2a4", {issue_valid_o, o2a_pending_o}, {1'b0, 3'd4});

    // reject path and clear
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    chk("s4_clear", {o2a_pending_o, issue_id_o, idle_o}, {3'd0, 4'd0, 1'b1});
    issue_accept_i = 1'b0;
    push(32'h0000_0055, 32'h1, 32'h2);
    tick();
    chk("s4_valid", {issue_valid_o, reject_err_o}, {1'b1, 1'b0});
    tick();
    chk("s4_reject", {reject_err_o, issue_valid_o, a2o_pending_o, issue_id_o, idle_o},
        {1'b1, 1'b0, 3'd0, 4'd0, 1'b1});
    issue_accept_i = 1'b1;
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    chk("s4_rej_cleared", reject_err_o, 0);

    // coincident accept/done, then underflow
    push(32'h10, 0, 0); tick(); tick();
    push(32'h11, 0, 0); tick(); tick();
    chk("s5_a2o2", a2o_pending_o, 2);
    push(32'h12, 0, 0); tick();
    chk("s5_valid", issue_valid_o, 1);
    axi2obi_done_i = 1'b1; tick(); axi2obi_done_i = 1'b0;
    chk("s5_coincident", {issue_valid_o, a2o_pending_o}, {1'b0, 3'd2});
    pulse_a2o_done(); pulse_a2o_done();
    chk("s5_a2o0", {a2o_pending_o, count_err_o}, {3'd0, 1'b0});
    pulse_a2o_done();
    chk("s5_underflow", {a2o_pending_o, count_err_o}, {3'd0, 1'b1});
    obi2axi_done_i = 1'b1; axi2obi_done_i = 1'b1; tick();
    obi2axi_done_i = 1'b0; axi2obi_done_i = 1'b0;
    chk("s5_both_done", {a2o_pending_o, o2a_pending_o, count_err_o}, {3'd0, 3'd0, 1'b1});

    // reset in the middle of an issue with a part-full FIFO
    push(32'h20, 0, 0); tick(); tick();
    issue_ready_i = 1'b0;
    push(32'h21, 0, 0); push(32'h22, 0, 0); push(O2A | 32'h23, 0, 0);
    chk("s6_busy", {issue_valid_o, a2o_pending_o, issue_id_o}, {1'b1, 3'd1, 4'd4});
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    chk("s6_rst", {issue_valid_o, cmd_ready_o, a2o_pending_o, o2a_pending_o, issue_id_o},
        {1'b0, 1'b1, 3'd0, 3'd0, 4'd0});
    chk("s6_rst_flags", {count_err_o, reject_err_o, idle_o}, {1'b0, 1'b0, 1'b1});
    tick();
    chk("s6_stays_idle", {issue_valid_o, idle_o}, {1'b0, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/idma_xif_issuer.md
Name: idma_xif_issuer

Overview:
- Initiator-side counterpart of the tile iDMA Xif controller.
- Accepts DMA commands (instruction word plus two operand registers) from a local requester (tile sequencer or test master) and buffers them in a FIFO.
- Drives them onto the Xif issue channel toward the iDMA controller and tracks outstanding transfers per direction (AXI2OBI / OBI2AXI) using the controller's done pulses.
- Throttles issue when a direction reaches its outstanding limit.

Parameters:
- INSTR_W, 32, instruction width.
- DATA_W, 32, operand register width.
- ID_W, 4, Xif instruction ID width.
- FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2).
- MAX_OUTSTANDING, 4, max in-flight transfers per direction (>=1).
- DIRECTION_OFF, 25, instruction bit selecting direction (0=AXI2OBI, 1=OBI2AXI).
- CNT_W, $clog2(MAX_OUTSTANDING+1), pending-counter width (derived).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- clear_i  in  1  synchronous soft clear, same effect as rst_i
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  FIFO can accept a command
- cmd_instr_i  in  INSTR_W  DMA instruction word
- cmd_rs0_i  in  DATA_W  operand 0
- cmd_rs1_i  in  DATA_W  operand 1
- issue_valid_o  out  1  Xif issue valid
- issue_ready_i  in  1  Xif issue ready
- issue_instr_o  out  INSTR_W  Xif issue_req.instr
- issue_rs0_o  out  DATA_W  Xif issue_req.rs[0]
- issue_rs1_o  out  DATA_W  Xif issue_req.rs[1]
- issue_id_o  out  ID_W  Xif issue_req.id
- issue_accept_i  in  1  Xif issue_resp.accept, sampled on handshake
- axi2obi_done_i  in  1  AXI2OBI transfer finished (pulse)
- obi2axi_done_i  in  1  OBI2AXI transfer finished (pulse)
- a2o_pending_o  out  CNT_W  AXI2OBI in-flight count
- o2a_pending_o  out  CNT_W  OBI2AXI in-flight count
- reject_err_o  out  1  sticky: a command was rejected
- count_err_o  out  1  sticky: done pulse received with pending count 0
- idle_o  out  1  FIFO empty, both counts 0, no issue in progress

Behaviour:
Reset and clear:
- rst_i or clear_i, sampled on clk_i rising edge, sets the following. FIFO empty; FSM IDLE; issue_id 0; both counters 0; both errors 0.
- Resulting outputs: cmd_ready_o=1, issue_valid_o=0, idle_o=1. Issue data outputs are 0.
- Reset or clear mid-handshake aborts the command with no response.
- clear_i takes priority over every other event in the same cycle.

FIFO:
- Push on cmd_valid_i && cmd_ready_o. cmd_ready_o = !full (no bypass).
- Push and pop in the same cycle are allowed when not full or empty.
- Pointer wrap is modulo FIFO_DEPTH.
- Head is visible to the FSM the cycle after the push, giving one-cycle minimum latency from command to issue_valid_o.

FSM:
- IDLE:
  - issue_valid_o=0.
  - Go to ISSUE when the FIFO is non-empty and the head's direction counter is below MAX_OUTSTANDING.
  - The direction bit is head instr[DIRECTION_OFF].
- ISSUE:
  - issue_valid_o=1. Instruction, rs0, rs1 and id are driven from registered head/ID and held stable until handshake.
  - Once valid, it is never withdrawn.
  - Handshake is issue_valid_o && issue_ready_i:
    - On accept (issue_accept_i=1): pop the FIFO, increment that direction's counter, increment issue_id (wraps at 2^ID_W).
    - On reject (issue_accept_i=0): pop the FIFO, set reject_err_o, issue_id unchanged, counter unchanged.
  - After handshake, go back to IDLE. Back-to-back issue is not required; one bubble cycle is allowed.
- Head-of-line blocking: a throttled head blocks all later commands, even those for the other direction.

Counters:
- Each counter changes by +1 on accepted issue of its direction and -1 on its done pulse.
- An accept and a done for the same direction in the same cycle leave the counter unchanged.
- A done pulse while the counter is 0: counter stays 0 and count_err_o is set.
- A counter never exceeds MAX_OUTSTANDING; this is guaranteed by the throttle.

Other outputs:
- Both done inputs may pulse in the same cycle; each updates independently.
- idle_o = FIFO empty && state==IDLE && both counters 0 (combinational).

Test Plan:
- Reset, then push one command (instr bit25=0, rs0=0x1000, rs1=0x2000) with issue_ready_i=1 and accept=1. Expect issue_valid_o 1 cycle after push, id=0, a2o_pending_o 0->1, idle_o=0. Pulse axi2obi_done_i: a2o_pending_o=0, idle_o=1.
- Hold issue_ready_i=0 for 5 cycles with a command pending. Expect issue_valid_o high and instr/rs/id stable for all 5 cycles; issue on the 6th cycle when ready=1.
- Push 5 OBI2AXI commands with FIFO_DEPTH=4 and issue_ready_i=0. Expect cmd_ready_o=0 after 4 pushes. Release ready: all issued with ids 0..3, o2a_pending_o=4, 5th command held until one obi2axi_done_i arrives.
- Issue with accept=0. Expect FIFO popped, reject_err_o=1, id unchanged, pending unchanged. clear_i clears reject_err_o.
- Accepted AXI2OBI issue coincident with axi2obi_done_i while a2o_pending_o=2. Expect count stays 2. Then done with count 0: expect count_err_o=1 and count stays 0.
- Assert rst_i mid-ISSUE with 3 FIFO entries. Next cycle: issue_valid_o=0, cmd_ready_o=1, counters 0, issue_id_o=0.
